ex_issue_stage: RTL and testbench
=================================

Name: ex_issue_stage

Overview:
- ID/EX pipeline stage directly upstream of the 64-bit ALU.
- Accepts decoded instructions from decode over a valid/ready handshake and buffers up to two entries (main register plus skid register).
- Generates the 4-bit ALU operation code and selects operand B.
- Presents a registered, stable operand/opcode bundle to the ALU, with backpressure and flush support.

Parameters:
- XLEN, 64, datapath width of operands and immediate.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  squash all buffered entries (branch mispredict/exception).
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_rs1_data  in  XLEN  operand A source.
- in_rs2_data  in  XLEN  register operand B source.
- in_imm  in  XLEN  sign-extended immediate.
- in_alu_src  in  1  1 = operand B is in_imm, 0 = in_rs2_data.
- in_alu_ctrl  in  2  main-control class: 00 mem, 01 branch, 10 arith/logic, 11 nor.
- in_funct3  in  3  instruction funct3.
- in_funct7b5  in  1  instruction bit 30.
- in_is_rtype  in  1  1 = R-type (funct7b5 meaningful for add/sub).
- in_rd  in  RD_W  destination register.
- in_reg_write  in  1  writeback enable.
- out_valid  out  1  bundle valid to ALU/EX.
- out_ready  in  1  downstream consumes the bundle.
- alu_a  out  XLEN  ALU operand a.
- alu_b  out  XLEN  ALU operand b.
- alu_op  out  4  ALU operation code.
- out_rd  out  RD_W  passed-through destination register.
- out_reg_write  out  1  passed-through writeback enable.
- out_illegal  out  1  unsupported operation decoded.

Behaviour:
- **Decode (at capture, combinational on inputs, stored in payload):**
  - ctrl 00 → 0010 (add).
  - ctrl 01 → 0110 (sub).
  - ctrl 11 → 1100 (nor).
  - ctrl 10, by funct3:
    - 000: 0110 if is_rtype & funct7b5, else 0010.
    - 111: 0000.
    - 110: 0001.
    - Any other funct3: alu_op = 1111 and illegal = 1.
  - illegal = 0 in all other cases.
- **Operand B:** alu_b = alu_src ? imm : rs2_data, selected at capture.
- **Storage:**
  - Entry M (main) drives all outputs; entry S (skid) holds overflow.
  - out_valid = M.valid.
  - in_ready = ~S.valid & ~flush & ~reset. in_ready depends only on registered state and flush/reset, never on out_ready.
  - accept = in_valid & in_ready.
  - pop = M.valid & out_ready.
- **Update each cycle (flush and reset not asserted):**
  - If ~M.valid or pop: M ← S if S.valid, else the new payload if accept, else invalid. S is then invalid.
  - Otherwise (M full and held):
    - If accept, S ← new payload.
    - M payload must not change while out_valid=1 and out_ready=0.
- **Ordering:**
  - Strictly FIFO; S never bypasses M.
  - Latency with an empty stage: 1 cycle from accept to out_valid.
- **Flush:**
  - Next edge: M.valid = S.valid = 0.
  - An input offered in the flush cycle is dropped (in_ready already 0).
  - Data registers may retain values.
- **Reset:**
  - Valid flags cleared.
  - alu_a, alu_b, out_rd, out_reg_write, out_illegal = 0; alu_op = 0010.
  - Reset mid-transfer discards both entries.
  - in_ready = 0 during reset, 1 in the cycle after.
- **Simultaneous events:**
  - reset > flush > handshake.
  - pop and accept in the same cycle with M full and S empty: M ← new, S stays empty.
  - S full: pop moves S to M, and in_ready rises the next cycle.
- No arithmetic is performed here; widths pass through unchanged.

Decomposition:
- Shared package (alu_pkg):
  - ALU opcode constants: ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_NOR=1100, ALU_ILL=1111.
  - ALU control class constants.
  - Packed payload struct: a, b, op, rd, reg_write, illegal.
- Sub-module alu_ctrl_decode (combinational ctrl/funct → op, illegal), reused by later stages and bench models.

Test Plan:
1. Reset for 2 cycles, then release → out_valid=0, in_ready=1, alu_a=alu_b=0, alu_op=0010 during and after reset.
2. R-type add: rs1=5, rs2=3, ctrl=10, f3=000, f7b5=0, rtype=1, out_ready=1 → next cycle out_valid=1, alu_op=0010, alu_a=5, alu_b=3.
3. R-type with f7b5=1 → alu_op=0110. I-type addi, f7b5=1, alu_src=1, imm=FFFF_FFFF_FFFF_FFFF → alu_op=0010, alu_b=all ones.
4. Backpressure: out_ready=0, push A then B → B in S, in_ready=0, third item not accepted. Raise out_ready → A then B on consecutive cycles, in_ready=1 the cycle after S empties.
5. Both entries full, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, offered item never appears.
6. ctrl=10, f3=001 → alu_op=1111, out_illegal=1. ctrl=11 → alu_op=1100, out_illegal=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode and control-class constants plus the
// operand/opcode payload carried from the issue stage into the ALU.
package alu_pkg;

  localparam int XLEN = 64;
  localparam int RD_W = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_ILL = 4'b1111;

  localparam logic [1:0] CTRL_MEM    = 2'b00;
  localparam logic [1:0] CTRL_BRANCH = 2'b01;
  localparam logic [1:0] CTRL_ARITH  = 2'b10;
  localparam logic [1:0] CTRL_NOR    = 2'b11;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      op;
    logic [RD_W-1:0] rd;
    logic            reg_write;
    logic            illegal;
  } issue_payload_t;

  localparam issue_payload_t PAYLOAD_RESET = '{
    a:         '0,
    b:         '0,
    op:        ALU_ADD,
    rd:        '0,
    reg_write: 1'b0,
    illegal:   1'b0
  };

endpackage

// File: rtl/alu_ctrl_decode.sv
// Maps the main-control class and funct fields onto a 4-bit ALU opcode.
// Purely combinational so later stages can reuse it unchanged.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_ctrl,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_rtype,
  output logic [3:0] op,
  output logic       illegal
);

  always_comb begin
    op      = ALU_ADD;
    illegal = 1'b0;
    unique case (alu_ctrl)
      CTRL_MEM:    op = ALU_ADD;
      CTRL_BRANCH: op = ALU_SUB;
      CTRL_NOR:    op = ALU_NOR;
      CTRL_ARITH: begin
        unique case (funct3)
          // funct7b5 only selects subtract for register-register forms;
          // immediates reuse bit 30 as part of the constant.
          F3_ADDSUB: op = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
          F3_AND:    op = ALU_AND;
          F3_OR:     op = ALU_OR;
          default: begin
            op      = ALU_ILL;
            illegal = 1'b1;
          end
        endcase
      end
      default: op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX issue stage: two-entry (main + skid) buffer in front of the ALU.
// Opcode and operand B are resolved at capture so the ALU sees a stable bundle.
module ex_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = alu_pkg::XLEN,
  parameter int RD_W = alu_pkg::RD_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_alu_src,
  input  logic [1:0]      in_alu_ctrl,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7b5,
  input  logic            in_is_rtype,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_reg_write,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  output logic [RD_W-1:0] out_rd,
  output logic            out_reg_write,
  output logic            out_illegal
);

  logic           m_valid;
  logic           s_valid;
  issue_payload_t m_q;
  issue_payload_t s_q;
  issue_payload_t new_pl;
  logic [3:0]     dec_op;
  logic           dec_illegal;
  logic           accept;
  logic           pop;

  alu_ctrl_decode u_decode (
    .alu_ctrl (in_alu_ctrl),
    .funct3   (in_funct3),
    .funct7b5 (in_funct7b5),
    .is_rtype (in_is_rtype),
    .op       (dec_op),
    .illegal  (dec_illegal)
  );

  always_comb begin
    new_pl           = PAYLOAD_RESET;
    new_pl.a         = in_rs1_data;
    new_pl.b         = in_alu_src ? in_imm : in_rs2_data;
    new_pl.op        = dec_op;
    new_pl.rd        = in_rd;
    new_pl.reg_write = in_reg_write;
    new_pl.illegal   = dec_illegal;
  end

  // Ready looks only at the skid flag, so it never combinationally
  // depends on out_ready.
  assign in_ready = ~s_valid & ~flush & ~reset;
  assign accept   = in_valid & in_ready;
  assign pop      = m_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_q     <= PAYLOAD_RESET;
      s_q     <= PAYLOAD_RESET;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!m_valid || pop) begin
      if (s_valid) begin
        m_q     <= s_q;
        m_valid <= 1'b1;
      end else if (accept) begin
        m_q     <= new_pl;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
      s_valid <= 1'b0;
    end else if (accept) begin
      s_q     <= new_pl;
      s_valid <= 1'b1;
    end
  end

  assign out_valid     = m_valid;
  assign alu_a         = m_q.a;
  assign alu_b         = m_q.b;
  assign alu_op        = m_q.op;
  assign out_rd        = m_q.rd;
  assign out_reg_write = m_q.reg_write;
  assign out_illegal   = m_q.illegal;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Bench for ex_issue_stage: directed scenarios then random traffic, all
// checked against a queue-based FIFO model with its own opcode rules.
module tb_ex_issue_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [63:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_alu_src;
  logic [1:0]  in_alu_ctrl;
  logic [2:0]  in_funct3;
  logic        in_funct7b5, in_is_rtype;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        out_valid, out_ready;
  logic [63:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_illegal;

  always #5 clk = ~clk;

  ex_issue_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_alu_src(in_alu_src), .in_alu_ctrl(in_alu_ctrl), .in_funct3(in_funct3),
    .in_funct7b5(in_funct7b5), .in_is_rtype(in_is_rtype),
    .in_rd(in_rd), .in_reg_write(in_reg_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_illegal(out_illegal)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } exp_t;

  exp_t q[$];
  exp_t head;
  exp_t rst_val;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  function automatic exp_t make_exp();
    exp_t e;
    e.a   = in_rs1_data;
    e.b   = in_alu_src ? in_imm : in_rs2_data;
    e.rd  = in_rd;
    e.rw  = in_reg_write;
    e.ill = 1'b0;
    case (in_alu_ctrl)
      2'd0: e.op = 4'b0010;
      2'd1: e.op = 4'b0110;
      2'd3: e.op = 4'b1100;
      default: begin
        if (in_funct3 == 3'd0)      e.op = (in_is_rtype && in_funct7b5) ? 4'b0110 : 4'b0010;
        else if (in_funct3 == 3'd7) e.op = 4'b0000;
        else if (in_funct3 == 3'd6) e.op = 4'b0001;
        else begin
          e.op  = 4'b1111;
          e.ill = 1'b1;
        end
      end
    endcase
    return e;
  endfunction

  // One clock: check DUT state between edges, then advance the model on the edge.
  task automatic step();
    exp_t nw;
    logic p, acc;
    @(negedge clk);
    check("out_valid", out_valid, q.size() != 0);
    check("in_ready", in_ready, (q.size() < 2) && !flush && !reset);
    check("alu_a", alu_a, head.a);
    check("alu_b", alu_b, head.b);
    check("alu_op", alu_op, head.op);
    check("out_rd", out_rd, head.rd);
    check("out_reg_write", out_reg_write, head.rw);
    check("out_illegal", out_illegal, head.ill);
    @(posedge clk);
    if (reset) begin
      q.delete();
      head = rst_val;
    end else if (flush) begin
      q.delete();
    end else begin
      p   = (q.size() != 0) && out_ready;
      acc = in_valid && (q.size() < 2);
      nw  = make_exp();
      if (p) void'(q.pop_front());
      if (acc) q.push_back(nw);
      if (q.size() != 0) head = q[0];
    end
    #1;
  endtask

  task automatic set_in(input logic v, input logic [63:0] rs1, input logic [63:0] rs2,
                        input logic [63:0] imm, input logic src, input logic [1:0] ctrl,
                        input logic [2:0] f3, input logic f7, input logic rt,
                        input logic [4:0] rd, input logic rw);
    in_valid = v; in_rs1_data = rs1; in_rs2_data = rs2; in_imm = imm;
    in_alu_src = src; in_alu_ctrl = ctrl; in_funct3 = f3; in_funct7b5 = f7;
    in_is_rtype = rt; in_rd = rd; in_reg_write = rw;
  endtask

  initial begin
    rst_val = '{a: 64'd0, b: 64'd0, op: 4'b0010, rd: 5'd0, rw: 1'b0, ill: 1'b0};
    head    = rst_val;
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    step(); step();
    reset = 1'b0;
    step();

    // R-type add, then sub, then addi with all-ones immediate
    out_ready = 1'b1;
    set_in(1, 64'd5, 64'd3, 64'd0, 0, 2'b10, 3'b000, 0, 1, 5'd7, 1); step();
    in_valid = 1'b0; step();
    set_in(1, 64'd9, 64'd4, 64'd0, 0, 2'b10, 3'b000, 1, 1, 5'd8, 1); step();
    set_in(1, 64'd4, 64'd1, '1, 1, 2'b10, 3'b000, 1, 0, 5'd9, 1); step();
    in_valid = 1'b0; step(); step();

    // Backpressure: A to main, B to skid, C refused until skid drains
    out_ready = 1'b0;
    set_in(1, 64'hA, 64'h1, 64'h0, 0, 2'b00, 3'b010, 0, 0, 5'd1, 1); step();
    set_in(1, 64'hB, 64'h2, 64'h0, 0, 2'b01, 3'b000, 0, 0, 5'd2, 0); step();
    set_in(1, 64'hC, 64'h3, 64'h0, 0, 2'b10, 3'b111, 0, 1, 5'd3, 1); step(); step();
    in_valid = 1'b0; out_ready = 1'b1; step(); step(); step();

    // Flush with both entries full and an item offered
    out_ready = 1'b0;
    set_in(1, 64'h11, 64'h0, 64'h0, 0, 2'b10, 3'b110, 0, 1, 5'd4, 1); step();
    set_in(1, 64'h22, 64'h0, 64'h0, 0, 2'b11, 3'b000, 0, 1, 5'd5, 1); step();
    set_in(1, 64'h33, 64'h0, 64'h0, 0, 2'b00, 3'b000, 0, 1, 5'd6, 1);
    flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step(); step();

    // Illegal funct3 and nor class
    set_in(1, 64'h5, 64'h6, 64'h0, 0, 2'b10, 3'b001, 0, 1, 5'd10, 1); step();
    set_in(1, 64'h7, 64'h8, 64'h0, 0, 2'b11, 3'b001, 0, 1, 5'd11, 1); step();
    in_valid = 1'b0; step(); step();

    for (int i = 0; i < 800; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      out_ready = ($urandom_range(0, 99) < 55);
      set_in($urandom_range(0, 99) < 65,
             {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)));
      step();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
